doa_sequencer: RTL and testbench
================================

# doa_sequencer

Frame-level controller for the direction-of-arrival path.
- On each completed FFT frame, scans channel-1 FFT RAM for the strongest bin and drives `maxbin` to `weightblock`.
- Pulses `detectdone` to start `weightblock`, waits for its `done`, then publishes `doa`/`bnum` as one result.
- Owns the channel-1 RAM read port: scan address during the scan, `maxbin` at all other times.
- Sits between the FFT write side and `weightblock`, replacing the hard-wired bin/trigger of bring-up.

## Interface
Parameters:
- `ADDR_W`, 10: FFT RAM address width.
- `BIN_LO`, 1: first bin scanned (skips DC).
- `BIN_HI`, 511: last bin scanned, inclusive; BIN_LO ≤ BIN_HI required.
- `MAG_THRESH`, 64: minimum peak magnitude to run `weightblock`.
- `TIMEOUT`, 4096: max cycles waiting for `wb_done`.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `frame_done`  in  1  one-cycle pulse: all four FFT RAMs hold a new frame.
- `ram1_rdaddr`  out  ADDR_W  channel-1 FFT RAM read address.
- `ram1_q`  in  28  channel-1 RAM data, 1-cycle read latency; [27:14] re, [13:0] im, signed.
- `maxbin`  out  ADDR_W  peak bin to `weightblock`; held between frames.
- `detectdone`  out  1  one-cycle start pulse to `weightblock`.
- `wb_done`  in  1  `weightblock` completion pulse.
- `wb_bnum`  in  4  `weightblock` beam number, valid with `wb_done`.
- `wb_doa`  in  8  `weightblock` DOA, valid with `wb_done`.
- `busy`  out  1  high in any state other than IDLE.
- `res_valid`  out  1  one-cycle pulse: result fields updated.
- `res_doa`  out  8  latched DOA.
- `res_bnum`  out  4  latched beam number.
- `res_bin`  out  ADDR_W  latched peak bin.
- `res_mag`  out  15  latched peak magnitude.
- `res_status`  out  2  0 ok, 1 no-signal, 2 timeout.
- `drop_cnt`  out  8  saturating count of dropped frames.

## Operation
- FSM states: IDLE, SCAN, DRAIN, TRIG, WAIT, REPORT.
- IDLE → SCAN on `frame_done`. Clear peak registers (mag 0, bin BIN_LO) and set scan address to BIN_LO.
- SCAN: present address a, a+1, … one per cycle. Data for address a is compared the following cycle.
  - Magnitude = |re| + |im|, 15-bit unsigned. |−8192| = 8192, so the maximum is 16384 with no overflow.
  - Update the peak only on strictly greater magnitude, so ties keep the lowest bin.
  - After issuing BIN_HI, go to DRAIN.
- DRAIN: compare the final sample.
  - If peak mag < MAG_THRESH → REPORT with status 1; `weightblock` is not started.
  - Otherwise → TRIG.
- TRIG: `maxbin` ← peak bin, `detectdone` = 1 for this cycle only, → WAIT.
- WAIT: count cycles.
  - On `wb_done`, latch `wb_doa`/`wb_bnum` and set status 0 → REPORT.
  - If the count reaches TIMEOUT with no `wb_done`, set status 2 → REPORT; `res_doa`/`res_bnum` keep their previous values.
- REPORT: update `res_bin`, `res_mag`, `res_status`; pulse `res_valid`; → IDLE.
- `ram1_rdaddr` = scan address in SCAN, `maxbin` in every other state.
- `frame_done` while `busy`: frame is dropped, `drop_cnt` += 1, saturating at 255.
- `frame_done` in the REPORT cycle is also dropped. It is accepted only in IDLE.
- `wb_done` outside WAIT is ignored.
- Reset asserted mid-frame: return to IDLE immediately; no `res_valid` is emitted for the aborted frame.

## Timing
- Reset values: all outputs 0. `maxbin` = BIN_LO, `ram1_rdaddr` = BIN_LO.
- N = BIN_HI − BIN_LO + 1.
- With `frame_done` at cycle 0:
  - SCAN occupies cycles 1..N.
  - DRAIN is cycle N+1.
  - TRIG is cycle N+2, where `detectdone` is high.
- `res_valid` comes 1 cycle after the REPORT transition.
  - Normal path: 2 cycles after `wb_done`.
  - No-signal path: at cycle N+3.
- Timeout: `res_valid` TIMEOUT+2 cycles after `detectdone`.
- `maxbin` is stable from TRIG until the next TRIG. `weightblock` may read it throughout WAIT.

## Structure
- Shared package `doa_pkg`:
  - state enum `seq_state_t`.
  - status constants `ST_OK`, `ST_NOSIG`, `ST_TIMEOUT`.
  - bin field slices `RE_MSB`=27, `RE_LSB`=14, `IM_MSB`=13, `IM_LSB`=0.
- One sub-module `peak_tracker`:
  - combinational abs-sum plus registered max/argmax.
  - ports: clear, valid, bin, sample.

## Test plan
- Single tone, constant-bin scan:
  - Stimulus: bin 44 = (−226, −310), mag 536; all other bins (3, 4).
  - Response: `maxbin` = 44 at TRIG, one `detectdone`; `wb_done` with doa = 60, bnum = 5 → `res_valid`, `res_doa` = 60, `res_bin` = 44, `res_mag` = 536, status 0.
- Tie:
  - Stimulus: bins 20 and 300 both mag 1000.
  - Response: `res_bin` = 20.
- Below threshold:
  - Stimulus: all bins mag ≤ 50.
  - Response: no `detectdone`; `res_valid` at cycle N+3 with status 1.
- Timeout:
  - Stimulus: `wb_done` never asserted.
  - Response: `res_valid` TIMEOUT+2 cycles after `detectdone`, status 2, `res_doa` unchanged.
- Overrun:
  - Stimulus: 3 `frame_done` pulses during WAIT, then 300 more while busy.
  - Response: `drop_cnt` = 3, then saturates at 255; one result only.
- Reset mid-WAIT:
  - Stimulus: assert `reset` low.
  - Response: outputs return to reset values asynchronously; no `res_valid`; next `frame_done` runs a full frame.

Source files
------------

// File: rtl/doa_pkg.sv
// doa_pkg: shared types, status codes and RAM word field positions for the DOA sequencer
package doa_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        DRAIN,
        TRIG,
        WAIT,
        REPORT
    } seq_state_t;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_NOSIG   = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;

    localparam int RE_MSB = 27;
    localparam int RE_LSB = 14;
    localparam int IM_MSB = 13;
    localparam int IM_LSB = 0;

    // Two's-complement magnitude; -8192 maps to 8192, which still fits in 14 unsigned bits.
    function automatic logic [13:0] abs14(input logic [13:0] x);
        return x[13] ? ~x + 14'd1 : x;
    endfunction

endpackage

// File: rtl/peak_tracker.sv
// peak_tracker: running max/argmax of |re|+|im| over a stream of FFT bins
// Ports: clk, reset (async active-low), clear (restart: mag 0, bin BIN_LO),
//        valid/bin/sample (one bin per cycle), peak_* (registered peak),
//        nxt_* (peak including the current sample, for same-cycle decisions).
module peak_tracker
    import doa_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int BIN_LO = 1
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              valid,
    input  logic [ADDR_W-1:0] bin,
    input  logic [27:0]       sample,
    output logic [14:0]       peak_mag,
    output logic [ADDR_W-1:0] peak_bin,
    output logic [14:0]       nxt_mag,
    output logic [ADDR_W-1:0] nxt_bin
);
    logic [14:0] mag;
    logic        upd;

    always_comb begin
        mag = {1'b0, abs14(sample[RE_MSB:RE_LSB])} + {1'b0, abs14(sample[IM_MSB:IM_LSB])};
        // Strictly greater: ties keep the earlier (lower) bin.
        upd = valid && (mag > peak_mag);
        nxt_mag = upd ? mag : peak_mag;
        nxt_bin = upd ? bin : peak_bin;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            peak_mag <= '0;
            peak_bin <= ADDR_W'(BIN_LO);
        end else if (clear) begin
            peak_mag <= '0;
            peak_bin <= ADDR_W'(BIN_LO);
        end else begin
            peak_mag <= nxt_mag;
            peak_bin <= nxt_bin;
        end
    end

endmodule

// File: rtl/doa_sequencer.sv
// doa_sequencer: per-frame peak-bin scan, weightblock trigger/handshake and DOA result publication
// Ports: clk, reset (async active-low), frame_done (new FFT frame), ram1_rdaddr/ram1_q
//        (channel-1 RAM, 1-cycle latency), maxbin/detectdone/wb_done/wb_bnum/wb_doa
//        (weightblock handshake), busy, res_* (result, res_valid pulse), drop_cnt.
module doa_sequencer
    import doa_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int BIN_LO     = 1,
    parameter int BIN_HI     = 511,
    parameter int MAG_THRESH = 64,
    parameter int TIMEOUT    = 4096
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_done,
    output logic [ADDR_W-1:0] ram1_rdaddr,
    input  logic [27:0]       ram1_q,
    output logic [ADDR_W-1:0] maxbin,
    output logic              detectdone,
    input  logic              wb_done,
    input  logic [3:0]        wb_bnum,
    input  logic [7:0]        wb_doa,
    output logic              busy,
    output logic              res_valid,
    output logic [7:0]        res_doa,
    output logic [3:0]        res_bnum,
    output logic [ADDR_W-1:0] res_bin,
    output logic [14:0]       res_mag,
    output logic [1:0]        res_status,
    output logic [7:0]        drop_cnt
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    seq_state_t        state, state_nx;
    logic [ADDR_W-1:0] addr, bin_d, peak_bin, nxt_bin;
    logic [14:0]       peak_mag, nxt_mag;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        st_r;
    logic              v_d, start, below, timed_out;

    // Read data lags the address by one cycle, so the compare uses the delayed address/valid.
    peak_tracker #(.ADDR_W(ADDR_W), .BIN_LO(BIN_LO)) u_peak (
        .clk      (clk),
        .reset    (reset),
        .clear    (start),
        .valid    (v_d),
        .bin      (bin_d),
        .sample   (ram1_q),
        .peak_mag (peak_mag),
        .peak_bin (peak_bin),
        .nxt_mag  (nxt_mag),
        .nxt_bin  (nxt_bin)
    );

    always_comb begin
        start       = (state == IDLE) && frame_done;
        below       = nxt_mag < 15'(MAG_THRESH);
        timed_out   = cnt == CNT_W'(TIMEOUT - 1);
        busy        = state != IDLE;
        detectdone  = state == TRIG;
        ram1_rdaddr = (state == SCAN) ? addr : maxbin;
        state_nx    = state;
        case (state)
            IDLE:    state_nx = frame_done ? SCAN : IDLE;
            SCAN:    state_nx = (addr == ADDR_W'(BIN_HI)) ? DRAIN : SCAN;
            DRAIN:   state_nx = below ? REPORT : TRIG;
            TRIG:    state_nx = WAIT;
            WAIT:    state_nx = (wb_done || timed_out) ? REPORT : WAIT;
            REPORT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr       <= ADDR_W'(BIN_LO);
            bin_d      <= ADDR_W'(BIN_LO);
            v_d        <= 1'b0;
            cnt        <= '0;
            st_r       <= ST_OK;
            maxbin     <= ADDR_W'(BIN_LO);
            res_valid  <= 1'b0;
            res_doa    <= '0;
            res_bnum   <= '0;
            res_bin    <= '0;
            res_mag    <= '0;
            res_status <= '0;
            drop_cnt   <= '0;
        end else begin
            addr  <= start ? ADDR_W'(BIN_LO) : (state == SCAN) ? addr + ADDR_W'(1) : addr;
            bin_d <= addr;
            v_d   <= state == SCAN;
            cnt   <= (state == WAIT) ? cnt + CNT_W'(1) : '0;
            if (state == DRAIN && below)  st_r   <= ST_NOSIG;
            if (state == DRAIN && !below) maxbin <= nxt_bin;
            if (state == WAIT && wb_done) begin
                res_doa  <= wb_doa;
                res_bnum <= wb_bnum;
                st_r     <= ST_OK;
            end else if (state == WAIT && timed_out) begin
                st_r <= ST_TIMEOUT;
            end
            res_valid <= state == REPORT;
            if (state == REPORT) begin
                res_bin    <= peak_bin;
                res_mag    <= peak_mag;
                res_status <= st_r;
            end
            if (frame_done && state != IDLE && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_doa_sequencer.sv
// tb_doa_sequencer: scoreboard bench for doa_sequencer with a behavioural RAM and weightblock responder
module tb_doa_sequencer;
    localparam int N  = 511;
    localparam int TO = 4096;

    logic        clk = 1'b0, reset = 1'b0, frame_done = 1'b0, wb_done = 1'b0;
    logic [3:0]  wb_bnum = 4'hF;
    logic [7:0]  wb_doa = 8'hAA;
    logic [27:0] ram1_q = '0;
    logic [27:0] mem [1024];
    logic [9:0]  ram1_rdaddr, maxbin, res_bin;
    logic        detectdone, busy, res_valid;
    logic [7:0]  res_doa, drop_cnt;
    logic [3:0]  res_bnum;
    logic [14:0] res_mag;
    logic [1:0]  res_status;

    typedef struct {
        logic [7:0]  doa;
        logic [3:0]  bnum;
        logic [9:0]  bin;
        logic [14:0] mag;
        logic [1:0]  st;
        int          cyc;
    } exp_t;

    exp_t       sb[$];
    logic [9:0] trig_q[$];
    exp_t       got;
    int         n_tests = 0, n_fail = 0, cyc = 0;

    doa_sequencer #(.ADDR_W(10), .BIN_LO(1), .BIN_HI(N), .MAG_THRESH(64), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .frame_done  (frame_done),
        .ram1_rdaddr (ram1_rdaddr),
        .ram1_q      (ram1_q),
        .maxbin      (maxbin),
        .detectdone  (detectdone),
        .wb_done     (wb_done),
        .wb_bnum     (wb_bnum),
        .wb_doa      (wb_doa),
        .busy        (busy),
        .res_valid   (res_valid),
        .res_doa     (res_doa),
        .res_bnum    (res_bnum),
        .res_bin     (res_bin),
        .res_mag     (res_mag),
        .res_status  (res_status),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) ram1_q <= mem[ram1_rdaddr];

    task automatic chk(input string nm, input int act, input int ex);
        n_tests++;
        if (act !== ex) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, ex);
        end
    endtask

    always @(negedge clk) begin
        if (reset && detectdone) begin
            if (trig_q.size() == 0) chk("unexpected_detectdone", 1, 0);
            else                    chk("maxbin_at_trig", maxbin, trig_q.pop_front());
        end
        if (reset && res_valid) begin
            if (sb.size() == 0) chk("unexpected_res_valid", 1, 0);
            else begin
                got = sb.pop_front();
                chk("res_doa", res_doa, got.doa);
                chk("res_bnum", res_bnum, got.bnum);
                chk("res_bin", res_bin, got.bin);
                chk("res_mag", res_mag, got.mag);
                chk("res_status", res_status, got.st);
                chk("res_valid_cycle", cyc, got.cyc);
            end
        end
    end

    function automatic logic [27:0] mk(input int re, input int im);
        return {14'(re), 14'(im)};
    endfunction

    task automatic fill(input int re, input int im);
        for (int i = 0; i < 1024; i++) mem[i] = mk(re, im);
    endtask

    task automatic pulse_wb(input logic [7:0] d, input logic [3:0] b);
        wb_done = 1'b1; wb_doa = d; wb_bnum = b;
        @(posedge clk); #1;
        wb_done = 1'b0; wb_doa = 8'hAA; wb_bnum = 4'hF;
    endtask

    // Pushes the expected result (when push is set) and issues one frame_done pulse.
    task automatic start(input exp_t e, input bit push, input bit trig, input int d);
        int c0;
        @(posedge clk); #1;
        c0 = cyc;
        e.cyc = (e.st == 2'd0) ? c0 + N + 4 + d : (e.st == 2'd1) ? c0 + N + 3 : c0 + N + 4 + TO;
        if (push) sb.push_back(e);
        if (trig) trig_q.push_back(e.bin);
        frame_done = 1'b1;
        @(posedge clk); #1;
        frame_done = 1'b0;
    endtask

    task automatic respond(input int d, input logic [7:0] doa, input logic [3:0] bnum);
        int k = 0;
        while (!detectdone && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        if (!detectdone) chk("detectdone_wait", 0, 1);
        else begin
            repeat (d) @(posedge clk);
            #1;
            pulse_wb(doa, bnum);
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (sb.size() != 0 && k < 6000) begin
            @(posedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            chk("res_valid_wait", 0, 1);
            sb.delete();
        end
        repeat (5) @(posedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_detectdone"}, detectdone, 0);
        chk({tag, "_maxbin"}, maxbin, 1);
        chk({tag, "_rdaddr"}, ram1_rdaddr, 1);
        chk({tag, "_res_doa"}, res_doa, 0);
        chk({tag, "_res_mag"}, res_mag, 0);
        chk({tag, "_res_status"}, res_status, 0);
        chk({tag, "_drop_cnt"}, drop_cnt, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        fill(0, 0);
        repeat (3) @(posedge clk);
        #1 check_reset_values("reset");
        @(negedge clk) reset = 1'b1;

        // Single tone; DC bin and bins past BIN_HI are loud but must be ignored.
        fill(3, 4);
        mem[0] = mk(5000, 0); mem[44] = mk(-226, -310); mem[600] = mk(7000, 7000);
        e = '{doa: 8'd60, bnum: 4'd5, bin: 10'd44, mag: 15'd536, st: 2'd0, cyc: 0};
        start(e, 1, 1, 3); respond(3, 8'd60, 4'd5); wait_idle();

        // Tie: lower bin wins.
        fill(1, 1);
        mem[20] = mk(600, -400); mem[300] = mk(-1000, 0);
        e = '{doa: 8'd61, bnum: 4'd6, bin: 10'd20, mag: 15'd1000, st: 2'd0, cyc: 0};
        start(e, 1, 1, 1); respond(1, 8'd61, 4'd6); wait_idle();

        // Peak at BIN_HI with the largest possible magnitude.
        fill(2, -2);
        mem[511] = mk(-8192, -8192); mem[0] = mk(8000, 8000); mem[512] = mk(7000, 7000);
        e = '{doa: 8'd62, bnum: 4'd7, bin: 10'd511, mag: 15'd16384, st: 2'd0, cyc: 0};
        start(e, 1, 1, 5); respond(5, 8'd62, 4'd7); wait_idle();

        // Just below threshold: no trigger, doa/bnum unchanged.
        fill(25, -25);
        mem[100] = mk(-33, 30);
        e = '{doa: 8'd62, bnum: 4'd7, bin: 10'd100, mag: 15'd63, st: 2'd1, cyc: 0};
        start(e, 1, 0, 0); wait_idle();

        // Exactly at threshold: triggers.
        fill(0, 0);
        mem[7] = mk(-64, 0);
        e = '{doa: 8'd63, bnum: 4'd8, bin: 10'd7, mag: 15'd64, st: 2'd0, cyc: 0};
        start(e, 1, 1, 2); respond(2, 8'd63, 4'd8); wait_idle();

        // Timeout; a stray wb_done during the scan must not touch the result.
        fill(3, 4);
        mem[44] = mk(-226, -310);
        e = '{doa: 8'd63, bnum: 4'd8, bin: 10'd44, mag: 15'd536, st: 2'd2, cyc: 0};
        start(e, 1, 1, 0);
        repeat (10) @(posedge clk);
        #1 pulse_wb(8'd99, 4'd3);
        wait_idle();

        // Overrun during WAIT: three drops, then saturation.
        fill(3, 4);
        mem[200] = mk(100, -100);
        e = '{doa: 8'd63, bnum: 4'd8, bin: 10'd200, mag: 15'd200, st: 2'd2, cyc: 0};
        start(e, 1, 1, 0);
        repeat (N + 20) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            #1 frame_done = 1'b1;
            @(posedge clk); #1 frame_done = 1'b0;
            @(posedge clk);
        end
        #1 chk("drop_cnt_3", drop_cnt, 3);
        for (int i = 0; i < 300; i++) begin
            frame_done = 1'b1;
            @(posedge clk); #1 frame_done = 1'b0;
            @(posedge clk); #1;
        end
        chk("drop_cnt_sat", drop_cnt, 255);
        wait_idle();
        repeat (20) @(posedge clk);
        #1 chk("drop_cnt_hold", drop_cnt, 255);

        // Reset mid-WAIT: asynchronous return to reset values, no result for the aborted frame.
        fill(3, 4);
        mem[44] = mk(-226, -310);
        e = '{doa: 8'd0, bnum: 4'd0, bin: 10'd44, mag: 15'd0, st: 2'd0, cyc: 0};
        start(e, 0, 1, 0);
        repeat (N + 30) @(posedge clk);
        #3 reset = 1'b0;
        #1 check_reset_values("async_reset");
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;

        // Next frame runs in full.
        e = '{doa: 8'd77, bnum: 4'd9, bin: 10'd44, mag: 15'd536, st: 2'd0, cyc: 0};
        start(e, 1, 1, 4); respond(4, 8'd77, 4'd9); wait_idle();
        chk("trig_queue_empty", trig_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
